uart_prog_loader: RTL and testbench

Upstream stage of the CPU core. It receives a Brainfuck program as a byte stream from the UART receiver and filters out every non-instruction character. Each surviving opcode is written sequentially into program SPRAM. The rest of program memory is then zero-padded and `loaded` is raised so the core may start. It also performs a bracket-balance check so malformed programs are flagged before execution.

---
 rtl/uart_prog_loader.sv | 164 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Receives a Brainfuck program byte stream, stores opcodes sequentially into program memory,
// zero-pads the remainder and flags capacity overflow and unbalanced brackets.
module uart_prog_loader #(
  parameter int          PROG_ADDR_WIDTH = 14,
  parameter int          PROG_LEN        = 16383,
  parameter logic [7:0]  TERMINATOR      = 8'h21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loading,
  output logic                       loaded,
  output logic [PROG_ADDR_WIDTH-1:0] prog_count,
  output logic                       overflow,
  output logic                       bracket_err
);

  localparam int                AW        = PROG_ADDR_WIDTH;
  localparam logic [AW-1:0]     LEN_C     = AW'(PROG_LEN);
  localparam logic [AW-1:0]     ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]       DEPTH_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wr_q, wr_d;
  logic            loading_q, loading_d;
  logic            loaded_q, loaded_d;
  logic [AW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            berr_q, berr_d;
  logic [AW:0]     depth_q, depth_d;
  logic [AW-1:0]   pad_q, pad_d;

  function automatic logic is_opcode(input logic [7:0] b);
    case (b)
      8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_opcode = 1'b1;
      default:                                                 is_opcode = 1'b0;
    endcase
  endfunction

  // Next-state and write-port logic
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    berr_d  = berr_q;
    depth_d = depth_q;
    pad_d   = pad_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_req) begin
          count_d = {AW{1'b0}};
          ovf_d   = 1'b0;
          berr_d  = 1'b0;
          depth_d = {(AW+1){1'b0}};
          state_d = S_RECV;
        end else begin
          state_d = state_q;
        end
      end
      S_RECV: begin
        if (rx_valid && (rx_byte == TERMINATOR)) begin
          berr_d  = berr_q | (depth_q != {(AW+1){1'b0}});
          pad_d   = count_q;
          state_d = S_PAD;
        end else if (rx_valid && is_opcode(rx_byte)) begin
          if (count_q < LEN_C) begin
            we_d    = 1'b1;
            addr_d  = count_q;
            wr_d    = rx_byte;
            count_d = count_q + ADDR_ONE;
          end else begin
            ovf_d = 1'b1;
          end
          // Depth follows every opcode, stored or dropped.
          if (rx_byte == 8'h5B) begin
            depth_d = depth_q + DEPTH_ONE;
          end else if (rx_byte == 8'h5D) begin
            if (depth_q != {(AW+1){1'b0}}) begin
              depth_d = depth_q - DEPTH_ONE;
            end else begin
              berr_d = 1'b1;
            end
          end else begin
            depth_d = depth_q;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_PAD: begin
        we_d   = 1'b1;
        addr_d = pad_q;
        wr_d   = 8'h00;
        pad_d  = pad_q + ADDR_ONE;
        // Equality compare: with PROG_LEN = 2^AW-1 the counter wraps right after.
        if (pad_q == LEN_C) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags line up with the registered write port, which lags state by a cycle.
    loading_d = (state_d == S_RECV) || (state_d == S_PAD) || (state_q == S_PAD);
    loaded_d  = (state_q == S_DONE) && (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= {AW{1'b0}};
      wr_q      <= 8'h00;
      loading_q <= 1'b0;
      loaded_q  <= 1'b0;
      count_q   <= {AW{1'b0}};
      ovf_q     <= 1'b0;
      berr_q    <= 1'b0;
      depth_q   <= {(AW+1){1'b0}};
      pad_q     <= {AW{1'b0}};
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      loaded_q  <= loaded_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      berr_q    <= berr_d;
      depth_q   <= depth_d;
      pad_q     <= pad_d;
    end
  end

  assign prog_we     = we_q;
  assign prog_addr   = addr_q;
  assign prog_wr     = wr_q;
  assign loading     = loading_q;
  assign loaded      = loaded_q;
  assign prog_count  = count_q;
  assign overflow    = ovf_q;
  assign bracket_err = berr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench: a default-size loader (a) and a PROG_LEN=4 loader (b) share clock, reset and rx.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req_a, load_req_b;
  logic        rx_valid;
  logic [7:0]  rx_byte;

  logic        we_a, loading_a, loaded_a, ovf_a, berr_a;
  logic [13:0] addr_a, count_a;
  logic [7:0]  wr_a;
  logic        we_b, loading_b, loaded_b, ovf_b, berr_b;
  logic [2:0]  addr_b, count_b;
  logic [7:0]  wr_b;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t qa[$];
  wr_t qb[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  uart_prog_loader dut_a (
    .clk(clk), .rst(rst), .load_req(load_req_a), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .prog_we(we_a), .prog_addr(addr_a), .prog_wr(wr_a), .loading(loading_a), .loaded(loaded_a),
    .prog_count(count_a), .overflow(ovf_a), .bracket_err(berr_a)
  );

  uart_prog_loader #(.PROG_ADDR_WIDTH(3), .PROG_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .load_req(load_req_b), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .prog_we(we_b), .prog_addr(addr_b), .prog_wr(wr_b), .loading(loading_b), .loaded(loaded_b),
    .prog_count(count_b), .overflow(ovf_b), .bracket_err(berr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write seen by each loader
  always @(negedge clk) begin
    if (we_a === 1'b1) qa.push_back('{int'(addr_a), int'(wr_a), cyc});
    if (we_b === 1'b1) qb.push_back('{int'(addr_b), int'(wr_b), cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      tick();
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) load_req_a = 1'b1; else load_req_b = 1'b1;
    tick();
    load_req_a = 1'b0;
    load_req_b = 1'b0;
  endtask

  task automatic wait_loaded(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? loaded_a : loaded_b) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_loaded", {31'd0, (which == 0) ? loaded_a : loaded_b}, 32'd1);
  endtask

  // Expected log: ops at 0..n-1, then 0x00 at every address up to len
  task automatic check_run(input string tag, input int which, input string ops, input int len);
    wr_t q[$];
    int  expd;
    logic ok;
    if (which == 0) q = qa; else q = qb;
    check({tag, "_nwr"}, q.size(), len + 1);
    ok = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      expd = (i < ops.len()) ? int'(ops[i]) : 0;
      if (q[i].addr != i || q[i].data != expd) ok = 1'b0;
    end
    check({tag, "_log"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; load_req_a = 1'b0; load_req_b = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {we_a, addr_a, wr_a, loading_a, loaded_a, count_a, ovf_a, berr_a}, 32'd0);
    check("rst_b", {we_b, addr_b, wr_b, loading_b, loaded_b, count_b, ovf_b, berr_b}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: "+[->+<]!" on the full-size loader
    pulse(0);
    send_byte("+");
    check("t1_lat", {we_a, 2'd0, addr_a, wr_a}, {1'b1, 2'd0, 14'd0, 8'h2B});
    tick();
    send_str("[->+<]!");
    tick();
    check("t1_padding", {loading_a, loaded_a, we_a}, {29'd0, 3'b101});
    wait_loaded(0, 17000);
    check("t1_count", count_a, 32'd7);
    check("t1_flags", {berr_a, ovf_a, we_a, loading_a}, 32'd0);
    check_run("t1", 0, "+[->+<]", 16383);

    // 2: restart from done, filtered stream
    pulse(0);
    check("t2_restart", {loaded_a, count_a}, 32'd0);
    qa.delete();
    send_str("a+\nb-!");
    wait_loaded(0, 17000);
    check("t2_count", count_a, 32'd2);
    check_run("t2", 0, "+-", 16383);

    // 3: unmatched ']' then open '[' at terminator
    pulse(1);
    qb.delete();
    send_byte("]");
    check("t3_berr_early", {berr_b, we_b, wr_b}, {22'd0, 2'b11, 8'h5D});
    tick();
    send_str("+[!");
    wait_loaded(1, 50);
    check("t3_final", {berr_b, ovf_b, count_b}, {27'd0, 2'b10, 3'd3});
    check_run("t3", 1, "]+[", 4);

    // 4: overflow past PROG_LEN=4
    pulse(1);
    check("t4_restart", {berr_b, count_b}, 32'd0);
    qb.delete();
    send_str("++++");
    check("t4_full", {ovf_b, count_b}, {28'd0, 1'b0, 3'd4});
    send_byte("+");
    check("t4_ovf", {ovf_b, count_b}, {28'd0, 1'b1, 3'd4});
    tick();
    send_str("++!");
    wait_loaded(1, 50);
    check("t4_final", {berr_b, ovf_b, count_b}, {27'd0, 2'b01, 3'd4});
    check_run("t4", 1, "++++", 4);

    // 5: asynchronous reset in the middle of padding
    pulse(1);
    send_str("+");
    send_byte("!");
    tick();
    check("t5_in_pad", {we_b, addr_b}, {28'd0, 1'b1, 3'd1});
    rst = 1'b1;
    #1;
    check("t5_rst_b", {we_b, addr_b, wr_b, loading_b, loaded_b, count_b, ovf_b, berr_b}, 32'd0);
    check("t5_rst_a", {loaded_a, count_a}, 32'd0);
    tick();
    rst = 1'b0;
    qb.delete();
    send_str("+");
    check("t5_idle_quiet", qb.size(), 32'd0);
    pulse(1);
    send_byte("!");
    wait_loaded(1, 50);
    check("t5_count", count_b, 32'd0);
    check_run("t5", 1, "", 4);

    // 6: back-to-back strobes, then restart from done
    pulse(1);
    qb.delete();
    send_byte("+");
    send_byte("-");
    send_byte(".");
    send_byte("!");
    wait_loaded(1, 50);
    check_run("t6", 1, "+-.", 4);
    check("t6_consec", {16'(qb[1].cyc - qb[0].cyc), 16'(qb[2].cyc - qb[1].cyc)}, {16'd1, 16'd1});
    send_str("+");
    check("t6_done_quiet", {16'(qb.size()), 13'd0, count_b}, {16'd5, 13'd0, 3'd3});
    check("t6_still_loaded", {31'd0, loaded_b}, 32'd1);
    pulse(1);
    check("t6_restart", {loaded_b, loading_b, count_b}, {27'd0, 2'b01, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
